// File: rtl/ddr_cfg_sequencer.sv
// ddr_cfg_sequencer: walks a command ROM (WRITE / POLL / DELAY / END) and issues
// each WRITE or POLL as one request/ack transaction toward the CSR master.
// Used to bring the DDR controller and PHY CSRs up after reset without a CPU.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for i_start
// FETCH   | one cycle of ROM read latency
// DECODE  | command word valid; latch fields, pick the next state
// SETUP   | two cycles with req low so the CSR master can capture addr/data
// REQ     | req high until ack or until the ack timeout expires
// GAP     | two cycles with req low; afterwards judge the poll result / advance
// DELAY   | count the delay field down to zero
// FINISH  | drop busy; record done or error
module ddr_cfg_sequencer #(
  parameter int ROM_ADDR_WIDTH = 8,
  parameter int CFG_ADDR_WIDTH = 28,
  parameter int CFG_DATA_WIDTH = 32,
  parameter int POLL_LIMIT     = 1024,
  parameter int ACK_TIMEOUT    = 4096
) (
  input  logic                      i_cfg_clk,
  input  logic                      i_cfg_reset,
  input  logic                      i_start,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_error,
  output logic [1:0]                o_error_code,
  output logic [ROM_ADDR_WIDTH-1:0] o_error_index,
  output logic [ROM_ADDR_WIDTH-1:0] o_rom_addr,
  input  logic [99:0]               i_rom_data,
  output logic [5:0]                o_cfg_tgt_id,
  output logic                      o_cfg_wr_rdn,
  output logic [CFG_ADDR_WIDTH-1:0] o_cfg_addr,
  output logic [CFG_DATA_WIDTH-1:0] o_cfg_wdata,
  output logic                      o_cfg_req,
  input  logic [CFG_DATA_WIDTH-1:0] i_cfg_rdata,
  input  logic                      i_cfg_ack
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_SETUP, S_REQ, S_GAP, S_DELAY, S_FINISH
  } state_t;

  localparam logic [1:0] OP_WRITE = 2'd0;
  localparam logic [1:0] OP_POLL  = 2'd1;
  localparam logic [1:0] OP_DELAY = 2'd2;

  localparam logic [1:0] ERR_POLL = 2'd1;
  localparam logic [1:0] ERR_ACK  = 2'd2;

  localparam int ACK_W  = $clog2(ACK_TIMEOUT + 1);
  localparam int POLL_W = $clog2(POLL_LIMIT + 1);
  localparam logic [ACK_W-1:0]  ACK_LAST  = ACK_W'(ACK_TIMEOUT - 1);
  localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_LIMIT - 1);

  state_t state, state_nxt;

  logic [1:0]                cmd_op;
  logic [CFG_DATA_WIDTH-1:0] cmd_data;
  logic [CFG_DATA_WIDTH-1:0] cmd_mask;
  logic [CFG_DATA_WIDTH-1:0] rdata_q;
  logic [31:0]               delay_cnt;
  logic [ACK_W-1:0]          ack_cnt;
  logic [POLL_W-1:0]         poll_cnt;
  logic                      phase;      // second cycle of SETUP / GAP
  logic                      advance;
  logic                      ack_to;
  logic                      poll_to;
  logic                      poll_retry;
  logic                      poll_match;

  assign poll_match = ((rdata_q ^ cmd_data) & cmd_mask) == '0;
  // Derived from the state register so a synchronous reset drops req on the same edge.
  assign o_cfg_req  = (state == S_REQ);

  // State register.
  always_ff @(posedge i_cfg_clk) begin
    if (i_cfg_reset) state <= S_IDLE;
    else             state <= state_nxt;
  end

  // Next-state decode and per-cycle decision strobes.
  always_comb begin
    state_nxt  = state;
    advance    = 1'b0;
    ack_to     = 1'b0;
    poll_to    = 1'b0;
    poll_retry = 1'b0;
    case (state)
      S_IDLE:   if (i_start) state_nxt = S_FETCH;
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: begin
        case (i_rom_data[99:98])
          OP_WRITE, OP_POLL: state_nxt = S_SETUP;
          OP_DELAY:          state_nxt = S_DELAY;
          default:           state_nxt = S_FINISH;
        endcase
      end
      S_SETUP:  if (phase) state_nxt = S_REQ;
      S_REQ: begin
        if (i_cfg_ack) begin
          state_nxt = S_GAP;
        end else if (ack_cnt == ACK_LAST) begin
          ack_to    = 1'b1;
          state_nxt = S_FINISH;
        end
      end
      S_GAP: begin
        if (phase) begin
          if (cmd_op == OP_WRITE || poll_match) begin
            advance = 1'b1;
          end else if (poll_cnt == POLL_LAST) begin
            poll_to   = 1'b1;
            state_nxt = S_FINISH;
          end else begin
            poll_retry = 1'b1;
            state_nxt  = S_SETUP;
          end
        end
      end
      S_DELAY:  if (delay_cnt == '0) advance = 1'b1;
      S_FINISH: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
    // Running off the end of the ROM behaves like END rather than wrapping to 0.
    if (advance) state_nxt = (o_rom_addr == '1) ? S_FINISH : S_FETCH;
  end

  // Datapath: command latch, counters, CSR fields and status flags.
  always_ff @(posedge i_cfg_clk) begin
    if (i_cfg_reset) begin
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_error       <= 1'b0;
      o_error_code  <= 2'd0;
      o_error_index <= '0;
      o_rom_addr    <= '0;
      o_cfg_tgt_id  <= '0;
      o_cfg_wr_rdn  <= 1'b0;
      o_cfg_addr    <= '0;
      o_cfg_wdata   <= '0;
      cmd_op        <= 2'd0;
      cmd_data      <= '0;
      cmd_mask      <= '0;
      rdata_q       <= '0;
      delay_cnt     <= '0;
      ack_cnt       <= '0;
      poll_cnt      <= '0;
      phase         <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_start) begin
            o_busy        <= 1'b1;
            o_done        <= 1'b0;
            o_error       <= 1'b0;
            o_error_code  <= 2'd0;
            o_error_index <= '0;
            o_rom_addr    <= '0;
          end
        end
        S_DECODE: begin
          cmd_op    <= i_rom_data[99:98];
          cmd_data  <= CFG_DATA_WIDTH'(i_rom_data[63:32]);
          cmd_mask  <= CFG_DATA_WIDTH'(i_rom_data[31:0]);
          delay_cnt <= i_rom_data[63:32];
          poll_cnt  <= '0;
          phase     <= 1'b0;
          if (i_rom_data[99:98] == OP_WRITE || i_rom_data[99:98] == OP_POLL) begin
            o_cfg_tgt_id <= i_rom_data[97:92];
            o_cfg_addr   <= CFG_ADDR_WIDTH'(i_rom_data[91:64]);
            o_cfg_wdata  <= CFG_DATA_WIDTH'(i_rom_data[63:32]);
            o_cfg_wr_rdn <= (i_rom_data[99:98] == OP_WRITE);
          end
        end
        S_SETUP: begin
          phase   <= ~phase;
          ack_cnt <= '0;
        end
        S_REQ: begin
          ack_cnt <= ack_cnt + 1'b1;
          if (i_cfg_ack) rdata_q <= i_cfg_rdata;
          if (ack_to)    o_error_code <= ERR_ACK;
        end
        S_GAP: begin
          phase <= ~phase;
          if (poll_retry) poll_cnt <= poll_cnt + 1'b1;
          if (poll_to)    o_error_code <= ERR_POLL;
        end
        S_DELAY: begin
          if (delay_cnt != '0) delay_cnt <= delay_cnt - 1'b1;
        end
        S_FINISH: begin
          o_busy <= 1'b0;
          if (o_error_code != 2'd0) begin
            o_error       <= 1'b1;
            o_error_index <= o_rom_addr;
          end else begin
            o_done <= 1'b1;
          end
        end
        default: ;
      endcase
      if (advance && o_rom_addr != '1) o_rom_addr <= o_rom_addr + 1'b1;
    end
  end

endmodule

// File: tb/tb_ddr_cfg_sequencer.sv
// Bench for ddr_cfg_sequencer: behavioural ROM and CSR responder, a request
// scoreboard, a table of single-command programs and a few hand sequences.
module tb_ddr_cfg_sequencer;

  localparam logic [1:0] OP_WR   = 2'd0;
  localparam logic [1:0] OP_POLL = 2'd1;
  localparam logic [1:0] OP_DLY  = 2'd2;
  localparam logic [1:0] OP_END  = 2'd3;

  logic        clk;
  logic        rst;
  logic        start;
  logic        busy, done, err;
  logic [1:0]  err_code;
  logic [7:0]  err_idx;
  logic [7:0]  rom_addr;
  logic [99:0] rom_data;
  logic [5:0]  tgt;
  logic        wr_rdn;
  logic [27:0] caddr;
  logic [31:0] wdata;
  logic        req;
  logic [31:0] rdata;
  logic        ack, resp_ack, stray_ack;

  logic [99:0] rom [256];
  int          ack_lat;
  logic [31:0] rd_default;
  logic [31:0] rd_q [$];
  logic [66:0] exp_q [$];

  int n_checks = 0;
  int n_fail   = 0;
  int nreq     = 0;
  int last_len = 0;
  int gap_at_rise = 0;

  typedef struct {
    logic [1:0]  op;
    logic [5:0]  tgt;
    logic [27:0] addr;
    logic [31:0] data;
    logic [31:0] mask;
    int          idx;
    int          ack_lat;
    logic [31:0] rdata;
    logic        exp_done;
    logic        exp_error;
    logic [1:0]  exp_code;
    int          exp_nreq;
    int          exp_len;
  } vec_t;

  vec_t vecs [9];

  ddr_cfg_sequencer #(
    .ROM_ADDR_WIDTH(8), .CFG_ADDR_WIDTH(28), .CFG_DATA_WIDTH(32),
    .POLL_LIMIT(4), .ACK_TIMEOUT(16)
  ) dut (
    .i_cfg_clk(clk), .i_cfg_reset(rst), .i_start(start),
    .o_busy(busy), .o_done(done), .o_error(err),
    .o_error_code(err_code), .o_error_index(err_idx),
    .o_rom_addr(rom_addr), .i_rom_data(rom_data),
    .o_cfg_tgt_id(tgt), .o_cfg_wr_rdn(wr_rdn), .o_cfg_addr(caddr),
    .o_cfg_wdata(wdata), .o_cfg_req(req),
    .i_cfg_rdata(rdata), .i_cfg_ack(ack)
  );

  assign ack = resp_ack | stray_ack;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Registered ROM: data follows the address by one cycle.
  always @(posedge clk) rom_data <= rom[rom_addr];

  task automatic check(input string name, input logic [99:0] act, input logic [99:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [99:0] cmd(input logic [1:0] op, input logic [5:0] t,
                                      input logic [27:0] a, input logic [31:0] d,
                                      input logic [31:0] m);
    return {op, t, a, d, m};
  endfunction

  // CSR responder: acks on the ack_lat-th cycle of req (never when ack_lat is 0).
  initial begin
    int rcnt;
    rcnt = 0;
    resp_ack = 1'b0;
    rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (req) rcnt++;
      else     rcnt = 0;
      if (req && ack_lat != 0 && rcnt == ack_lat) begin
        resp_ack = 1'b1;
        if (rd_q.size() > 0) rdata = rd_q.pop_front();
        else                 rdata = rd_default;
      end else begin
        resp_ack = 1'b0;
      end
    end
  end

  // Monitor: scoreboard pop on each req rise, setup/hold stability, gap length.
  initial begin
    logic [66:0] cur, h1, h2, rise_f, exp_t;
    logic        prev_req, unstable;
    int          len, low_run;
    prev_req = 1'b0; unstable = 1'b0; len = 0; low_run = 0;
    h1 = '0; h2 = '0; rise_f = '0;
    forever begin
      @(negedge clk);
      cur = {wr_rdn, tgt, caddr, wdata};
      if (req && !prev_req) begin
        nreq++;
        gap_at_rise = low_run;
        check("req_low_gap_ge2", 100'(low_run >= 2), 100'(1));
        check("setup_fields_stable", 100'((h1 == cur) && (h2 == cur)), 100'(1));
        check("sb_has_expected", 100'(exp_q.size() != 0), 100'(1));
        if (exp_q.size() != 0) begin
          exp_t = exp_q.pop_front();
          check("sb_txn", 100'(cur), 100'(exp_t));
        end
        rise_f = cur; unstable = 1'b0; len = 0;
      end
      if (req) begin
        len++;
        low_run = 0;
        if (cur != rise_f) unstable = 1'b1;
      end else begin
        if (prev_req) begin
          last_len = len;
          check("req_fields_held", 100'(unstable), 100'(0));
        end
        low_run++;
      end
      h2 = h1; h1 = cur; prev_req = req;
    end
  end

  // Pulse start, optionally pulse it again at cycle mid_start, wait for completion.
  task automatic run_table(input int budget, input int mid_start);
    bit fin;
    fin = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int c = 0; c < budget && !fin; c++) begin
      @(negedge clk);
      start = (c == mid_start);
      if (!busy && (done || err)) fin = 1'b1;
    end
    start = 1'b0;
    check("run_completes", 100'(fin), 100'(1));
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = cmd(OP_END, 0, 0, 0, 0);
  endtask

  initial begin
    int n0;
    int exp_ra;
    rst = 1'b1; start = 1'b0; stray_ack = 1'b0; ack_lat = 0; rd_default = '0;
    clear_rom();

    vecs[0] = '{OP_WR,   6'h1A, 28'h100,     32'hDEADBEEF, 32'h0,    0, 5, 32'h0,    1'b1, 1'b0, 2'd0, 1, 5};
    vecs[1] = '{OP_WR,   6'h03, 28'hFFFFFFC, 32'h12345678, 32'h0,    2, 1, 32'h0,    1'b1, 1'b0, 2'd0, 1, 1};
    vecs[2] = '{OP_POLL, 6'h07, 28'h40,      32'h0F,       32'h0F,   1, 3, 32'hFF,   1'b1, 1'b0, 2'd0, 1, 3};
    vecs[3] = '{OP_POLL, 6'h09, 28'h80,      32'h1,        32'h1,    3, 2, 32'h0,    1'b0, 1'b1, 2'd1, 4, 2};
    vecs[4] = '{OP_WR,   6'h11, 28'h200,     32'hA5A5A5A5, 32'h0,    1, 0, 32'h0,    1'b0, 1'b1, 2'd2, 1, 16};
    vecs[5] = '{OP_DLY,  6'h00, 28'h0,       32'h0,        32'h0,    0, 1, 32'h0,    1'b1, 1'b0, 2'd0, 0, 0};
    vecs[6] = '{OP_END,  6'h00, 28'h0,       32'h0,        32'h0,    2, 1, 32'h0,    1'b1, 1'b0, 2'd0, 0, 0};
    vecs[7] = '{OP_POLL, 6'h2C, 28'h44,      32'hFFFF,     32'h0,    0, 4, 32'h0,    1'b1, 1'b0, 2'd0, 1, 4};
    vecs[8] = '{OP_POLL, 6'h3F, 28'h1000,    32'h00F0,     32'h00F0, 2, 2, 32'h12F3, 1'b1, 1'b0, 2'd0, 1, 2};

    repeat (3) @(negedge clk);
    check("rst_busy",     100'(busy),     100'(0));
    check("rst_done",     100'(done),     100'(0));
    check("rst_error",    100'(err),      100'(0));
    check("rst_code",     100'(err_code), 100'(0));
    check("rst_err_idx",  100'(err_idx),  100'(0));
    check("rst_rom_addr", 100'(rom_addr), 100'(0));
    check("rst_req",      100'(req),      100'(0));
    check("rst_fields",   100'({tgt, wr_rdn, caddr, wdata}), 100'(0));
    rst = 1'b0;
    @(negedge clk);

    // Table: one command at index idx, preceded by zero-length delays, followed by END.
    for (int v = 0; v < 9; v++) begin
      clear_rom();
      for (int k = 0; k < vecs[v].idx; k++) rom[k] = cmd(OP_DLY, 0, 0, 0, 0);
      rom[vecs[v].idx] = cmd(vecs[v].op, vecs[v].tgt, vecs[v].addr, vecs[v].data, vecs[v].mask);
      ack_lat = vecs[v].ack_lat;
      rd_default = vecs[v].rdata;
      if (vecs[v].op == OP_WR || vecs[v].op == OP_POLL)
        for (int n = 0; n < vecs[v].exp_nreq; n++)
          exp_q.push_back({vecs[v].op == OP_WR, vecs[v].tgt, vecs[v].addr, vecs[v].data});
      n0 = nreq;
      run_table(2000, -1);
      exp_ra = vecs[v].exp_error ? vecs[v].idx :
               (vecs[v].op == OP_END ? vecs[v].idx : vecs[v].idx + 1);
      check("vec_done",     100'(done),      100'(vecs[v].exp_done));
      check("vec_error",    100'(err),       100'(vecs[v].exp_error));
      check("vec_code",     100'(err_code),  100'(vecs[v].exp_code));
      check("vec_err_idx",  100'(err_idx),   100'(vecs[v].exp_error ? vecs[v].idx : 0));
      check("vec_rom_addr", 100'(rom_addr),  100'(exp_ra));
      check("vec_nreq",     100'(nreq - n0), 100'(vecs[v].exp_nreq));
      check("vec_sb_empty", 100'(exp_q.size()), 100'(0));
      check("vec_req_low",  100'(req),       100'(0));
      if (vecs[v].exp_nreq > 0) check("vec_req_len", 100'(last_len), 100'(vecs[v].exp_len));
      exp_q.delete();
      repeat (3) @(negedge clk);
    end

    // Poll that matches on the third read.
    clear_rom();
    rom[0] = cmd(OP_POLL, 6'h05, 28'h40, 32'h1, 32'h1);
    ack_lat = 2; rd_default = 32'h0;
    rd_q.push_back(32'h0); rd_q.push_back(32'h0); rd_q.push_back(32'h3);
    for (int n = 0; n < 3; n++) exp_q.push_back({1'b0, 6'h05, 28'h40, 32'h1});
    n0 = nreq;
    run_table(500, -1);
    check("poll3_nreq",     100'(nreq - n0),     100'(3));
    check("poll3_done",     100'(done),          100'(1));
    check("poll3_error",    100'(err),           100'(0));
    check("poll3_rd_used",  100'(rd_q.size()),   100'(0));
    check("poll3_sb_empty", 100'(exp_q.size()),  100'(0));
    check("poll3_rom_addr", 100'(rom_addr),      100'(1));
    rd_q.delete(); exp_q.delete();
    repeat (3) @(negedge clk);

    // WRITE, DELAY 10, WRITE with a start pulse during the run.
    clear_rom();
    rom[0] = cmd(OP_WR, 6'h0A, 28'h10, 32'h11111111, 32'h0);
    rom[1] = cmd(OP_DLY, 0, 0, 32'd10, 32'h0);
    rom[2] = cmd(OP_WR, 6'h0B, 28'h14, 32'h22222222, 32'h0);
    ack_lat = 3;
    exp_q.push_back({1'b1, 6'h0A, 28'h10, 32'h11111111});
    exp_q.push_back({1'b1, 6'h0B, 28'h14, 32'h22222222});
    n0 = nreq;
    run_table(500, 18);
    check("dly_gap_cycles", 100'(gap_at_rise),  100'(19));
    check("dly_nreq",       100'(nreq - n0),    100'(2));
    check("dly_done",       100'(done),         100'(1));
    check("dly_rom_addr",   100'(rom_addr),     100'(3));
    check("dly_sb_empty",   100'(exp_q.size()), 100'(0));
    exp_q.delete();
    repeat (3) @(negedge clk);

    // Reset while req is high, a stray ack afterwards, then a clean rerun.
    clear_rom();
    rom[0] = cmd(OP_WR, 6'h02, 28'h300, 32'h0BADF00D, 32'h0);
    ack_lat = 0;
    exp_q.push_back({1'b1, 6'h02, 28'h300, 32'h0BADF00D});
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int c = 0; c < 50 && !req; c++) @(negedge clk);
    check("rst_mid_req_seen", 100'(req), 100'(1));
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_req",  100'(req),  100'(0));
    check("rst_mid_busy", 100'(busy), 100'(0));
    check("rst_mid_done", 100'(done), 100'(0));
    rst = 1'b0;
    @(negedge clk); stray_ack = 1'b1;
    @(negedge clk); stray_ack = 1'b0;
    @(negedge clk);
    check("stray_ack_busy", 100'(busy), 100'(0));
    check("stray_ack_req",  100'(req),  100'(0));
    check("stray_ack_err",  100'(err),  100'(0));
    ack_lat = 2;
    exp_q.push_back({1'b1, 6'h02, 28'h300, 32'h0BADF00D});
    n0 = nreq;
    run_table(500, -1);
    check("rerun_nreq",     100'(nreq - n0),    100'(1));
    check("rerun_done",     100'(done),         100'(1));
    check("rerun_error",    100'(err),          100'(0));
    check("rerun_rom_addr", 100'(rom_addr),     100'(1));
    check("rerun_sb_empty", 100'(exp_q.size()), 100'(0));

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ddr_cfg_sequencer.md
Name: ddr_cfg_sequencer

Overview:
- Command-table-driven sequencer that sits directly upstream of the AXI-NAP CSR master on the DDR configuration path.
- Fetches commands from an external ROM: writes, read-polls, delays and end-of-table.
- Issues each command as a single config request/ack transaction and reports done or error.
- Used to bring up the DDR controller and PHY CSRs after reset without a soft processor.

Parameters:
ROM_ADDR_WIDTH, 8, command ROM index width (max 256 commands)
CFG_ADDR_WIDTH, 28, CSR byte address width
CFG_DATA_WIDTH, 32, CSR data width
POLL_LIMIT, 1024, max read attempts per POLL command before timeout error
ACK_TIMEOUT, 4096, max cycles waiting for i_cfg_ack before timeout error

Ports:
i_cfg_clk  in  1  config clock; all logic on rising edge
i_cfg_reset  in  1  synchronous, active-high reset
i_start  in  1  pulse: run table from index 0; ignored while busy
o_busy  out  1  sequence in progress
o_done  out  1  sticky: END reached without error; cleared by i_start
o_error  out  1  sticky: sequence aborted; cleared by i_start
o_error_code  out  2  0 none, 1 poll timeout, 2 ack timeout, 3 bad opcode
o_error_index  out  ROM_ADDR_WIDTH  ROM index of failing command
o_rom_addr  out  ROM_ADDR_WIDTH  command ROM read address
i_rom_data  in  100  command word; valid 1 cycle after o_rom_addr changes
o_cfg_tgt_id  out  6  CSR target ID
o_cfg_wr_rdn  out  1  1 write, 0 read
o_cfg_addr  out  CFG_ADDR_WIDTH  CSR byte address, 4-byte aligned
o_cfg_wdata  out  CFG_DATA_WIDTH  write data
o_cfg_req  out  1  request; held until ack
i_cfg_rdata  in  CFG_DATA_WIDTH  read data; valid with i_cfg_ack
i_cfg_ack  in  1  1-cycle acknowledge from CSR master

Behaviour:
- Command word: [99:98] opcode, [97:92] tgt_id, [91:64] addr, [63:32] data, [31:0] mask.
- Opcodes: 0 WRITE, 1 POLL, 2 DELAY (data = cycle count), 3 END.
- Reset values: all outputs 0; state IDLE.
- States: IDLE, FETCH, DECODE, SETUP, REQ, GAP, DELAY, FINISH.
- IDLE: on i_start, clear done/error/error_code/error_index, set o_rom_addr=0 and o_busy=1, go to FETCH.
- FETCH: one wait cycle for ROM latency, then DECODE.
- DECODE: register the command word.
  - WRITE/POLL: drive tgt_id, addr, wdata (data field) and wr_rdn (1 for WRITE, 0 for POLL) → SETUP.
  - DELAY: load counter with data → DELAY; data=0 passes through in 1 cycle.
  - END → FINISH.
- SETUP: 2 cycles with o_cfg_req=0 and fields stable, then REQ. This is required by the downstream address/data capture timing.
- REQ: o_cfg_req=1; all o_cfg_* fields held constant. The ack counter increments each cycle.
  - On i_cfg_ack: drop req the next cycle and go to GAP.
  - Counter reaching ACK_TIMEOUT: error code 2, drop req, go to FINISH.
- GAP: 2 cycles with req=0 (lets downstream leave its wait state), then:
  - WRITE: advance to the next command.
  - POLL: if (rdata & mask) == (data & mask), advance to the next command. Otherwise increment the poll counter and go to SETUP. Poll counter reaching POLL_LIMIT: error code 1 → FINISH.
  - rdata is captured on the ack cycle.
- Advance: o_rom_addr+1 → FETCH. If o_rom_addr is at its maximum value, treat as END (no wrap).
- DELAY: decrement counter; at 0, advance.
- FINISH: o_busy=0. Set o_done if no error; on error, set o_error and o_error_index=o_rom_addr. Then IDLE.
- Opcode is 2 bits, so all values are defined. Code 3 (bad opcode) is reserved for a future wider opcode field and is never set now.
- Poll counter resets per command; ack counter resets per request.
- i_start while busy is ignored.
- i_cfg_ack outside REQ is ignored.
- Reset mid-transaction: req drops immediately (same edge). The downstream ack may still arrive later and is ignored.

Test Plan:
- Table [WRITE tgt 0x1A addr 0x100 data 0xDEADBEEF; END], ack 5 cycles after req → req held 5 cycles; o_cfg_addr=0x100 and wdata=0xDEADBEEF stable from 2 cycles before req until ack; o_done=1, o_error=0.
- POLL addr 0x40 data 0x1 mask 0x1; rdata returns 0x0, 0x0, 0x3 → exactly 3 read requests each separated by ≥2 low cycles; advances after the 3rd; done=1.
- POLL that never matches, POLL_LIMIT=4 → 4 requests, o_error=1, code=1, o_error_index=POLL's index, busy=0.
- No ack, ACK_TIMEOUT=16 → req high exactly 16 cycles then low; error code 2.
- DELAY data=10 between two WRITEs → 10 extra idle cycles (±FETCH/DECODE overhead fixed at 2) between first ack and second SETUP; i_start pulsed mid-run ignored.
- Assert i_cfg_reset while req high → next cycle req=0, busy=0, done=0; fresh i_start reruns from index 0.
